// File: rtl/ret_addr_stack_pkg.sv
// rtl/ret_addr_stack_pkg.sv - shared constants and checkpoint record for the return-address stack
package ret_addr_stack_pkg;

    localparam int DEF_IP_WIDTH = 48;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_NCHK     = 4;

    // Sized for the largest supported DEPTH (64) so one record type serves every build
    localparam int MAX_SP_W  = 6;
    localparam int MAX_CNT_W = 7;

    typedef struct packed {
        logic [MAX_SP_W-1:0]  sp;
        logic [MAX_CNT_W-1:0] count;
    } chk_rec_t;

endpackage

// File: rtl/ret_addr_stack_chk.sv
// rtl/ret_addr_stack_chk.sv - checkpoint register file, one write port and one combinational read port
module ret_addr_stack_chk
    import ret_addr_stack_pkg::*;
#(
    parameter int NCHK = DEF_NCHK,
    localparam int TAG_W = $clog2(NCHK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [TAG_W-1:0] wrTag,
    input  chk_rec_t         wrData,
    input  logic [TAG_W-1:0] rdTag,
    output chk_rec_t         rdData
);

    chk_rec_t slots [NCHK];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCHK; i++) begin
                slots[i] <= '0;
            end
        end else if (wrEn) begin
            slots[wrTag] <= wrData;
        end
    end

    assign rdData = slots[rdTag];

endmodule

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - circular return-address stack with checkpoint/restore and flush
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int IP_WIDTH = DEF_IP_WIDTH,
    parameter int NCHK     = DEF_NCHK,
    localparam int SP_W  = $clog2(DEPTH),
    localparam int TAG_W = $clog2(NCHK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [IP_WIDTH-1:0] push_ip,
    input  logic                pop,
    input  logic                chk_en,
    input  logic [TAG_W-1:0]    chk_tag,
    input  logic                restore,
    input  logic [TAG_W-1:0]    restore_tag,
    input  logic                flush,
    output logic                pop_valid,
    output logic [IP_WIDTH-1:0] pop_ip,
    output logic                underflow,
    output logic [SP_W:0]       count,
    output logic                empty,
    output logic                full
);

    localparam logic [SP_W:0] FULL_COUNT = (SP_W+1)'(DEPTH);

    logic [IP_WIDTH-1:0] entries [DEPTH];
    logic [SP_W-1:0]     sp, spNext, wrAddr;
    logic [SP_W:0]       countNext;
    logic                wrEn, chkWrEn, popValidNext, underflowNext;
    logic [IP_WIDTH-1:0] popIpNext;
    chk_rec_t            chkWrData, chkRdData;
    logic                unusedChkBits;

    always_comb begin
        spNext        = sp;
        countNext     = count;
        wrEn          = 1'b0;
        wrAddr        = sp;
        chkWrEn       = 1'b0;
        popValidNext  = 1'b0;
        underflowNext = 1'b0;
        popIpNext     = pop_ip;
        if (flush) begin
            countNext = '0;
        end else if (restore) begin
            spNext    = chkRdData.sp[SP_W-1:0];
            countNext = chkRdData.count[SP_W:0];
        end else begin
            chkWrEn = chk_en;
            if (push && pop && count != '0) begin
                // Call+ret in one cycle replaces TOS in place
                popValidNext = 1'b1;
                popIpNext    = entries[sp];
                wrEn         = 1'b1;
            end else if (push) begin
                // Also covers push+pop on empty, which reports the failed pop
                wrEn          = 1'b1;
                wrAddr        = sp + 1'b1;
                spNext        = sp + 1'b1;
                underflowNext = pop;
                if (count != FULL_COUNT) begin
                    countNext = count + 1'b1;
                end
            end else if (pop) begin
                if (count != '0) begin
                    popValidNext = 1'b1;
                    popIpNext    = entries[sp];
                    spNext       = sp - 1'b1;
                    countNext    = count - 1'b1;
                end else begin
                    underflowNext = 1'b1;
                end
            end
        end
    end

    assign chkWrData = '{sp: MAX_SP_W'(spNext), count: MAX_CNT_W'(countNext)};
    assign unusedChkBits = ^chkRdData;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            underflow <= 1'b0;
            pop_ip    <= '0;
        end else begin
            sp        <= spNext;
            count     <= countNext;
            pop_valid <= popValidNext;
            underflow <= underflowNext;
            pop_ip    <= popIpNext;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            entries[wrAddr] <= push_ip;
        end
    end

    ret_addr_stack_chk #(.NCHK(NCHK)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (chkWrEn),
        .wrTag  (chk_tag),
        .wrData (chkWrData),
        .rdTag  (restore_tag),
        .rdData (chkRdData)
    );

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb/tb_ret_addr_stack.sv - vector table plus scoreboard bench for ret_addr_stack
module tb_ret_addr_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push, pop, chk_en, restore, flush;
    logic [47:0] push_ip;
    logic [1:0]  chk_tag, restore_tag;
    logic        pop_valid, underflow, empty, full;
    logic [47:0] pop_ip;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ret_addr_stack dut (
        .clk(clk), .rst(rst), .push(push), .push_ip(push_ip), .pop(pop),
        .chk_en(chk_en), .chk_tag(chk_tag), .restore(restore), .restore_tag(restore_tag),
        .flush(flush), .pop_valid(pop_valid), .pop_ip(pop_ip), .underflow(underflow),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        string       name;
        bit          push;
        logic [47:0] ip;
        bit          pop;
        bit          chk;
        logic [1:0]  ctag;
        bit          rest;
        logic [1:0]  rtag;
        bit          fl;
        int          expCnt;
        bit          expPv;
        logic [47:0] expIp;
        bit          expUf;
    } vec_t;

    typedef struct {
        string       name;
        int          cnt;
        bit          pv;
        logic [47:0] ip;
        bit          uf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string nm, bit pu, logic [47:0] ip, bit po, bit ck, int ct,
                                bit rs, int rt, bit fl, int cnt, bit pv, logic [47:0] eip, bit uf);
        vec_t v;
        v.name = nm; v.push = pu; v.ip = ip; v.pop = po; v.chk = ck; v.ctag = 2'(ct);
        v.rest = rs; v.rtag = 2'(rt); v.fl = fl; v.expCnt = cnt; v.expPv = pv;
        v.expIp = eip; v.expUf = uf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idleInputs();
        push = 0; pop = 0; chk_en = 0; restore = 0; flush = 0;
        push_ip = '0; chk_tag = '0; restore_tag = '0;
    endtask

    task automatic applyVec(input vec_t v);
        exp_t e;
        @(negedge clk);
        push = v.push; push_ip = v.ip; pop = v.pop; chk_en = v.chk; chk_tag = v.ctag;
        restore = v.rest; restore_tag = v.rtag; flush = v.fl;
        sb.push_back('{name: v.name, cnt: v.expCnt, pv: v.expPv, ip: v.expIp, uf: v.expUf});
        @(posedge clk);
        #1;
        idleInputs();
        if (sb.size() == 0) begin
            check({v.name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({e.name, "_count"}, 64'(count), 64'(e.cnt));
            check({e.name, "_empty"}, 64'(empty), 64'(e.cnt == 0));
            check({e.name, "_full"}, 64'(full), 64'(e.cnt == 16));
            check({e.name, "_pop_valid"}, 64'(pop_valid), 64'(e.pv));
            check({e.name, "_underflow"}, 64'(underflow), 64'(e.uf));
            if (e.pv) check({e.name, "_pop_ip"}, 64'(pop_ip), 64'(e.ip));
        end
    endtask

    initial begin
        rst = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 64'(count), 0);
        check("reset_empty", 64'(empty), 1);
        check("reset_full", 64'(full), 0);
        check("reset_pop_valid", 64'(pop_valid), 0);
        check("reset_underflow", 64'(underflow), 0);
        check("reset_pop_ip", 64'(pop_ip), 0);
        @(negedge clk);
        rst = 1'b1;

        // basic LIFO
        vecs.push_back(mk("lifo_push1", 1, 48'h1000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("lifo_push2", 1, 48'h2000, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("lifo_push3", 1, 48'h3000, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("lifo_pop1", 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 48'h3000, 0));
        vecs.push_back(mk("lifo_pop2", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 48'h2000, 0));
        vecs.push_back(mk("lifo_pop3", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 48'h1000, 0));
        vecs.push_back(mk("lifo_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // simultaneous push+pop replaces TOS
        vecs.push_back(mk("pp_pushA0", 1, 48'hA0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pp_pushB0", 1, 48'hB0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("pp_both", 1, 48'hC0, 1, 0, 0, 0, 0, 0, 2, 1, 48'hB0, 0));
        vecs.push_back(mk("pp_popC0", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 48'hC0, 0));
        vecs.push_back(mk("pp_popA0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 48'hA0, 0));
        // checkpoint / restore
        vecs.push_back(mk("ck_push10", 1, 48'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("ck_push20", 1, 48'h20, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("ck_save1", 0, 0, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("ck_push30", 1, 48'h30, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("ck_pop30", 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 48'h30, 0));
        vecs.push_back(mk("ck_pop20", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 48'h20, 0));
        vecs.push_back(mk("ck_restore1", 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0));
        vecs.push_back(mk("ck_pop_after", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 48'h20, 0));
        vecs.push_back(mk("ck_push40_save2", 1, 48'h40, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("ck_push50", 1, 48'h50, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("ck_restore_prio", 1, 48'h99, 1, 1, 3, 1, 2, 0, 2, 0, 0, 0));
        vecs.push_back(mk("ck_pop40", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 48'h40, 0));
        // flush priority and empty-stack pops
        vecs.push_back(mk("fl_all", 1, 48'h55, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("fl_pop_under", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("fl_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("em_pushpop", 1, 48'h77, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("em_pop77", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 48'h77, 0));

        foreach (vecs[i]) applyVec(vecs[i]);

        // overflow wraps over the oldest entry, then drain to underflow
        for (int i = 1; i <= 17; i++)
            applyVec(mk($sformatf("ov_push%0d", i), 1, 48'hA000 + 48'(i), 0, 0, 0, 0, 0, 0,
                        (i > 16) ? 16 : i, 0, 0, 0));
        for (int k = 1; k <= 16; k++)
            applyVec(mk($sformatf("ov_pop%0d", k), 0, 0, 1, 0, 0, 0, 0, 0,
                        16 - k, 1, 48'hA000 + 48'(18 - k), 0));
        applyVec(mk("ov_pop17", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // reset mid-pop discards the in-flight result
        for (int i = 1; i <= 3; i++)
            applyVec(mk($sformatf("rs_push%0d", i), 1, 48'hE0 + 48'(i), 0, 0, 0, 0, 0, 0, i, 0, 0, 0));
        @(negedge clk);
        pop = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rs_async_count", 64'(count), 0);
        check("rs_async_pop_valid", 64'(pop_valid), 0);
        @(negedge clk);
        pop = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_after_pop_valid", 64'(pop_valid), 0);
        check("rs_after_count", 64'(count), 0);
        check("rs_after_sp", 64'(dut.sp), 0);
        check("rs_after_empty", 64'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 16, stack entries (power of two, 4..64).
REQ-002 SHALL have parameter IP_WIDTH, default 48, return-address width.
REQ-003 SHALL have parameter NCHK, default 4, checkpoint slots (power of two).
REQ-004 SHALL have ports, one per line:
  clk  in  1  sole clock, all state on rising edge
  rst  in  1  asynchronous, active-low reset
  push  in  1  call decoded (pushCallStack qualified by valid)
  push_ip  in  IP_WIDTH  return address (call IP + call length)
  pop  in  1  ret decoded (popCallStack qualified by valid)
  chk_en  in  1  capture checkpoint this cycle
  chk_tag  in  log2(NCHK)  checkpoint slot written
  restore  in  1  mispredict recovery
  restore_tag  in  log2(NCHK)  checkpoint slot read
  flush  in  1  discard all entries
  pop_valid  out  1  pop_ip valid (registered)
  pop_ip  out  IP_WIDTH  predicted return target (registered)
  underflow  out  1  pop attempted on empty, one-cycle pulse
  count  out  log2(DEPTH)+1  live entries
  empty  out  1  count==0
  full  out  1  count==DEPTH

Function
REQ-005 SHALL hold a circular array of DEPTH entries, a top-of-stack pointer sp (log2(DEPTH) bits, modulo wrap) and count.
REQ-006 Push alone SHALL write push_ip at sp+1, set sp=sp+1, and set count=min(count+1,DEPTH).
REQ-007 Push when full SHALL overwrite the oldest entry silently; count stays DEPTH.
REQ-008 Pop alone with count>0 SHALL drive pop_ip=entry[sp], pop_valid=1 next cycle, set sp=sp-1, and set count=count-1.
REQ-009 Pop with count==0 SHALL leave sp/count unchanged, drive pop_valid=0, hold pop_ip, and pulse underflow=1 next cycle.
REQ-010 Simultaneous push+pop SHALL return old entry[sp] as pop_ip, write push_ip at sp, and leave sp/count unchanged; when empty it SHALL behave as push plus underflow.
REQ-011 pop_valid and underflow SHALL be 0 in any cycle following no pop.
REQ-012 chk_en SHALL store {sp,count} after the same cycle's push/pop update into slot chk_tag.
REQ-013 restore SHALL load sp/count from slot restore_tag; same-cycle push/pop/chk_en SHALL be ignored; entry contents SHALL NOT be rolled back.
REQ-014 flush SHALL set count=0 and leave sp unchanged; it has priority over restore, push and pop; pop_valid=0 next cycle.
REQ-015 Priority SHALL be flush > restore > push/pop/chk_en.
REQ-016 empty/full/count SHALL be combinational from registered count; pop latency SHALL be exactly one cycle.

Reset
REQ-017 On rst low, asynchronously: sp=0, count=0, pop_valid=0, underflow=0, pop_ip=0, all checkpoints={0,0}; array contents are don't-care.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight pop result; the first cycle after deassertion SHALL show pop_valid=0.

Structure
REQ-019 Shared package SHALL hold IP_WIDTH, the default DEPTH/NCHK, and the checkpoint record typedef {sp,count}.
REQ-020 Checkpoint storage SHALL be sub-module ret_addr_stack_chk (NCHK-entry register file, one write port, one read port).
REQ-021 Entry array SHALL be a flop/latch-free register array with no reset on data.

Verification
REQ-022 Reset, push 0x1000,0x2000,0x3000, then pop x3 -> pop_ip 0x3000,0x2000,0x1000 with pop_valid=1 each following cycle; count 3->0; empty=1.
REQ-023 DEPTH=16: push 17 addresses A1..A17 -> full=1, count=16; pop x16 returns A17..A2; 17th pop -> underflow=1, pop_valid=0.
REQ-024 count=2 (TOS 0xB0): push 0xC0 with pop same cycle -> pop_ip=0xB0, count=2; next pop -> 0xC0.
REQ-025 Push 0x10,0x20; chk_en tag=1; push 0x30; pop; pop; restore tag=1 -> count=2; pop -> 0x20.
REQ-026 Same cycle flush+restore+push -> count=0, empty=1; next pop -> underflow=1.
REQ-027 rst low during cycle with pop on count=3 -> next cycle pop_valid=0, count=0, sp=0.
